// File: rtl/uart_bram_pkg.sv
// Shared state encoding, status bytes and command bit positions for the
// UART-to-EBR command controller.
package uart_bram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    COUNT,
    RD_ISSUE,
    RD_LATCH,
    TX_BYTE,
    TX_WAIT,
    RX_DATA,
    WR_MEM,
    RX_CSUM,
    TX_STATUS
  } state_t;

  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] CSUM_ERR = 8'hE1;
  localparam logic [7:0] NAK      = 8'hE0;

  localparam int CMD_RSVD = 7;
  localparam int CMD_WR   = 6;
  localparam int CMD_WB   = 5;
  localparam int CMD_CSUM = 4;

  function automatic int ceil_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_bram_cmd_ctrl_watchdog.sv
// Rising-edge detect on the receive strobe plus an inter-byte timeout
// down-counter that reloads on every accepted byte or on restart.
module uart_rx_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_rx_valid,
  input  logic restart,
  output logic byte_stb,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic          rx_valid_q;
  logic [CW-1:0] cnt;

  assign byte_stb = uart_rx_valid & ~rx_valid_q;
  // Terminal count only matters on a cycle that neither reloads nor accepts.
  assign timeout  = ~restart & ~byte_stb & (cnt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid_q <= 1'b0;
      cnt        <= LOAD;
    end else begin
      rx_valid_q <= uart_rx_valid;
      if (restart || byte_stb)
        cnt <= LOAD;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_bram_cmd_ctrl.sv
// Byte-serial command parser performing multi-word block reads/writes to a
// selectable EBR bank, with optional XOR checksum and status replies.
//
// state     | meaning
// IDLE      | waiting for a command byte
// ADDR      | collecting base address bytes, MSB first
// COUNT     | collecting word count (N-1) bytes, MSB first
// RD_ISSUE  | rd_en pulse for the current word
// RD_LATCH  | capture mem_out into the shift register
// TX_BYTE   | launch the top byte of the shift register
// TX_WAIT   | skip one cycle, then wait for the transmitter to go idle
// RX_DATA   | assembling one write word
// WR_MEM    | wr_en pulse for the assembled word
// RX_CSUM   | waiting for the host checksum byte
// TX_STATUS | launch a status or read-checksum byte, then finish
module uart_bram_cmd_ctrl
  import uart_bram_pkg::*;
#(
  parameter int DATA_BYTES      = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int MEM_SELECT_BITS = 4,
  parameter int NUM_BLOCKS      = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rx_valid,
  input  logic [7:0]                 receive_data,
  input  logic                       uart_tx_busy,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  input  logic [8*DATA_BYTES-1:0]    mem_out,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [8*DATA_BYTES-1:0]    write_data,
  output logic                       rd_en,
  output logic                       wr_en,
  output logic                       warmboot,
  output logic                       busy,
  output logic                       error
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int AB  = ceil_bytes(ADDR_WIDTH);
  localparam int FW  = 8 * AB;
  localparam int BIW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int FIW = (AB > 1) ? $clog2(AB) : 1;

  localparam logic [BIW-1:0]             LAST_BYTE = BIW'(DATA_BYTES - 1);
  localparam logic [FIW-1:0]             LAST_FLD  = FIW'(AB - 1);
  localparam logic [ADDR_WIDTH:0]        ONE_WORD  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0]      ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [MEM_SELECT_BITS:0]   NB        = (MEM_SELECT_BITS + 1)'(NUM_BLOCKS);

  state_t                     state, state_n;
  logic [ADDR_WIDTH-1:0]      base, base_n, offset, offset_n;
  logic [FW-1:0]              fld, fld_n, fld_next;
  logic [FIW-1:0]             fld_cnt, fld_cnt_n;
  logic [ADDR_WIDTH:0]        words_left, words_left_n;
  logic [BIW-1:0]             byte_idx, byte_idx_n;
  logic [DW-1:0]              shift, shift_n, shift_in;
  logic [7:0]                 csum, csum_n, status, status_n;
  logic                       wr_op, wr_op_n, csum_en, csum_en_n;
  logic                       final_q, final_n, wait_first, wait_first_n;
  logic [MEM_SELECT_BITS-1:0] mem_select_n;
  logic                       warmboot_n, error_n;
  logic                       byte_stb, timeout, armed, bank_bad;

  uart_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rx_valid(uart_rx_valid),
    .restart      (~armed),
    .byte_stb     (byte_stb),
    .timeout      (timeout)
  );

  assign armed    = (state == ADDR) || (state == COUNT) ||
                    (state == RX_DATA) || (state == RX_CSUM);
  assign fld_next = (fld << 8) | FW'(receive_data);
  assign shift_in = (shift << 8) | DW'(receive_data);
  assign bank_bad = {1'b0, receive_data[MEM_SELECT_BITS-1:0]} >= NB;
  assign mem_addr   = base + offset;
  assign write_data = shift;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      base       <= '0;
      offset     <= '0;
      fld        <= '0;
      fld_cnt    <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      csum       <= '0;
      status     <= '0;
      wr_op      <= 1'b0;
      csum_en    <= 1'b0;
      final_q    <= 1'b0;
      wait_first <= 1'b0;
      mem_select <= '0;
      warmboot   <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      base       <= base_n;
      offset     <= offset_n;
      fld        <= fld_n;
      fld_cnt    <= fld_cnt_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      shift      <= shift_n;
      csum       <= csum_n;
      status     <= status_n;
      wr_op      <= wr_op_n;
      csum_en    <= csum_en_n;
      final_q    <= final_n;
      wait_first <= wait_first_n;
      mem_select <= mem_select_n;
      warmboot   <= warmboot_n;
      error      <= error_n;
    end
  end

  always_comb begin
    state_n      = state;
    base_n       = base;
    offset_n     = offset;
    fld_n        = fld;
    fld_cnt_n    = fld_cnt;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    shift_n      = shift;
    csum_n       = csum;
    status_n     = status;
    wr_op_n      = wr_op;
    csum_en_n    = csum_en;
    final_n      = final_q;
    wait_first_n = wait_first;
    mem_select_n = mem_select;
    warmboot_n   = warmboot;
    error_n      = error;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;

    case (state)
      IDLE: begin
        final_n = 1'b0;
        if (byte_stb) begin
          if (receive_data[CMD_RSVD] || bank_bad) begin
            status_n = NAK;
            error_n  = 1'b1;
            state_n  = TX_STATUS;
          end else begin
            mem_select_n = receive_data[MEM_SELECT_BITS-1:0];
            warmboot_n   = receive_data[CMD_WB];
            wr_op_n      = receive_data[CMD_WR];
            csum_en_n    = receive_data[CMD_CSUM];
            error_n      = 1'b0;
            fld_n        = '0;
            fld_cnt_n    = '0;
            state_n      = ADDR;
          end
        end
      end

      ADDR, COUNT: begin
        if (timeout) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (byte_stb) begin
          fld_n = fld_next;
          if (fld_cnt == LAST_FLD) begin
            fld_n     = '0;
            fld_cnt_n = '0;
            if (state == ADDR) begin
              base_n  = fld_next[ADDR_WIDTH-1:0];
              state_n = COUNT;
            end else begin
              // Count field carries N-1; the extra bit holds N = 2^ADDR_WIDTH.
              words_left_n = {1'b0, fld_next[ADDR_WIDTH-1:0]} + ONE_WORD;
              offset_n     = '0;
              byte_idx_n   = '0;
              csum_n       = '0;
              shift_n      = '0;
              state_n      = wr_op ? RX_DATA : RD_ISSUE;
            end
          end else begin
            fld_cnt_n = fld_cnt + 1'b1;
          end
        end
      end

      RD_ISSUE: begin
        rd_en   = 1'b1;
        state_n = RD_LATCH;
      end

      RD_LATCH: begin
        shift_n    = mem_out;
        byte_idx_n = '0;
        state_n    = TX_BYTE;
      end

      TX_BYTE: begin
        uart_tx_en   = 1'b1;
        uart_tx_data = shift[DW-1 -: 8];
        csum_n       = csum ^ shift[DW-1 -: 8];
        wait_first_n = 1'b1;
        state_n      = TX_WAIT;
      end

      TX_STATUS: begin
        uart_tx_en   = 1'b1;
        uart_tx_data = status;
        final_n      = 1'b1;
        wait_first_n = 1'b1;
        state_n      = TX_WAIT;
      end

      TX_WAIT: begin
        wait_first_n = 1'b0;
        if (!wait_first && !uart_tx_busy) begin
          if (final_q) begin
            state_n = IDLE;
          end else if (byte_idx == LAST_BYTE) begin
            byte_idx_n   = '0;
            offset_n     = offset + ADDR_ONE;
            words_left_n = words_left - ONE_WORD;
            if (words_left == ONE_WORD) begin
              if (csum_en) begin
                status_n = csum;
                state_n  = TX_STATUS;
              end else begin
                state_n = IDLE;
              end
            end else begin
              state_n = RD_ISSUE;
            end
          end else begin
            shift_n    = shift << 8;
            byte_idx_n = byte_idx + 1'b1;
            state_n    = TX_BYTE;
          end
        end
      end

      RX_DATA: begin
        if (timeout) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (byte_stb) begin
          shift_n = shift_in;
          csum_n  = csum ^ receive_data;
          if (byte_idx == LAST_BYTE) begin
            byte_idx_n = '0;
            state_n    = WR_MEM;
          end else begin
            byte_idx_n = byte_idx + 1'b1;
          end
        end
      end

      WR_MEM: begin
        wr_en        = 1'b1;
        offset_n     = offset + ADDR_ONE;
        words_left_n = words_left - ONE_WORD;
        if (words_left == ONE_WORD) begin
          if (csum_en) begin
            state_n = RX_CSUM;
          end else begin
            status_n = ACK;
            state_n  = TX_STATUS;
          end
        end else begin
          state_n = RX_DATA;
        end
      end

      RX_CSUM: begin
        if (timeout) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (byte_stb) begin
          if (receive_data == csum) begin
            status_n = ACK;
          end else begin
            status_n = CSUM_ERR;
            error_n  = 1'b1;
          end
          state_n = TX_STATUS;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bram_cmd_ctrl.sv
// Self-checking bench: directed command scenarios plus randomized block
// transfers compared against a word-level memory/transaction model.
module tb_uart_bram_cmd_ctrl;

  localparam int DB  = 2;
  localparam int AW  = 8;
  localparam int MSB = 4;
  localparam int NB  = 12;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          resetn;
  logic          uart_rx_valid;
  logic [7:0]    receive_data;
  logic          uart_tx_busy;
  logic          uart_tx_en;
  logic [7:0]    uart_tx_data;
  logic [15:0]   mem_out;
  logic [3:0]    mem_select;
  logic [7:0]    mem_addr;
  logic [15:0]   write_data;
  logic          rd_en, wr_en, warmboot, busy, error;

  always #5 clk = ~clk;

  uart_bram_cmd_ctrl #(
    .DATA_BYTES(DB), .ADDR_WIDTH(AW), .MEM_SELECT_BITS(MSB),
    .NUM_BLOCKS(NB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_rx_valid(uart_rx_valid),
    .receive_data(receive_data), .uart_tx_busy(uart_tx_busy),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .mem_out(mem_out),
    .mem_select(mem_select), .mem_addr(mem_addr), .write_data(write_data),
    .rd_en(rd_en), .wr_en(wr_en), .warmboot(warmboot), .busy(busy), .error(error)
  );

  int vectors = 0;
  int miscompares = 0;
  int both_hi = 0;

  logic [15:0] ebr [NB][256];
  int ref_mem [NB][256];
  int tx_log[$], wr_log[$], rd_log[$];
  int exp_tx[$], exp_wr[$], exp_rd[$];
  int wq[$];
  int exp_sel = 0;
  int exp_wb = 0;
  int exp_err = 0;
  bit rd_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // EBR emulation, transmitter-side logging and strobe monitoring.
  initial begin
    mem_out = '0;
    forever begin
      @(negedge clk);
      if (rd_en && wr_en) both_hi++;
      if (wr_en) begin
        wr_log.push_back(int'({mem_select, mem_addr, write_data}));
        if (int'(mem_select) < NB) ebr[mem_select][mem_addr] = write_data;
      end
      if (rd_en) begin
        rd_log.push_back(int'({mem_select, mem_addr}));
        mem_out = (int'(mem_select) < NB) ? ebr[mem_select][mem_addr] : 16'hDEAD;
        rd_hold = 1;
      end else if (rd_hold) begin
        rd_hold = 0;
      end else begin
        mem_out = 16'($urandom);
      end
      if (uart_tx_en) tx_log.push_back(int'(uart_tx_data));
    end
  end

  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_en) begin
        uart_tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        uart_tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    receive_data  = b;
    uart_rx_valid = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, busy, 0);
  endtask

  task automatic clear_logs();
    tx_log.delete(); wr_log.delete(); rd_log.delete();
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic compare_all(input string tag);
    check({tag, " tx_n"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      check($sformatf("%s tx%0d", tag, i), tx_log[i], exp_tx[i]);
    check({tag, " wr_n"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wr_log[i], exp_wr[i]);
    check({tag, " rd_n"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check($sformatf("%s rd%0d", tag, i), rd_log[i], exp_rd[i]);
    check({tag, " error"}, error, exp_err);
    check({tag, " warmboot"}, warmboot, exp_wb);
    check({tag, " mem_select"}, mem_select, exp_sel);
    clear_logs();
  endtask

  // Words to write come from wq (n = wq.size()).
  task automatic run_write(input string tag, input int bank, input int base,
                           input int use_cs, input int wb, input int bad);
    int n = wq.size();
    int cs = 0;
    send_byte(8'(32'h40 | (wb << 5) | (use_cs << 4) | bank));
    send_byte(8'(base));
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      send_byte(8'(wq[i] >> 8));
      send_byte(8'(wq[i]));
      cs = cs ^ ((wq[i] >> 8) & 'hFF) ^ (wq[i] & 'hFF);
      exp_wr.push_back((bank << 24) | (((base + i) % 256) << 16) | wq[i]);
      ref_mem[bank][(base + i) % 256] = wq[i];
    end
    if (use_cs != 0) send_byte(8'(cs ^ (bad != 0 ? 1 : 0)));
    exp_tx.push_back((use_cs != 0 && bad != 0) ? 'hE1 : 'hA5);
    exp_err = (use_cs != 0 && bad != 0) ? 1 : 0;
    exp_sel = bank;
    exp_wb  = wb;
    wait_idle(tag);
    compare_all(tag);
  endtask

  task automatic run_read(input string tag, input int bank, input int base,
                          input int n, input int use_cs, input int wb);
    int cs = 0;
    send_byte(8'(((wb << 5) | (use_cs << 4) | bank)));
    send_byte(8'(base));
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      int a = (base + i) % 256;
      int w = ref_mem[bank][a];
      exp_rd.push_back((bank << 8) | a);
      exp_tx.push_back((w >> 8) & 'hFF);
      exp_tx.push_back(w & 'hFF);
      cs = cs ^ ((w >> 8) & 'hFF) ^ (w & 'hFF);
    end
    if (use_cs != 0) exp_tx.push_back(cs);
    exp_err = 0;
    exp_sel = bank;
    exp_wb  = wb;
    wait_idle(tag);
    compare_all(tag);
  endtask

  task automatic run_invalid(input string tag, input logic [7:0] cmd);
    send_byte(cmd);
    exp_tx.push_back('hE0);
    exp_err = 1;
    wait_idle(tag);
    compare_all(tag);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    uart_rx_valid = 1'b0;
    receive_data = 8'h00;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) begin
        ebr[b][a] = 16'($urandom);
        ref_mem[b][a] = int'(ebr[b][a]);
      end
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst outs", {uart_tx_en, rd_en, wr_en, warmboot, error, uart_tx_data}, 0);
    check("rst mem", {mem_select, mem_addr, write_data}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();

    // Write 0x1234, 0xABCD to bank 3 @0x10 with good checksum
    wq = '{'h1234, 'hABCD};
    run_write("t1", 3, 'h10, 1, 0, 0);
    run_read("t2", 3, 'h10, 2, 0, 0);
    run_read("t3", 3, 'hFF, 2, 1, 0);
    wq = '{'h1234, 'hABCD};
    run_write("t4", 3, 'h10, 1, 0, 1);
    run_read("t4 clear", 3, 'h10, 1, 0, 1);

    // Bank boundary: NUM_BLOCKS-1 valid, NUM_BLOCKS rejected
    run_invalid("bank12", 8'h0C);
    run_read("bank11", 11, 'h7F, 3, 1, 0);

    // Inter-byte timeout after the command byte
    @(negedge clk);
    receive_data = 8'h03;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    repeat (95) @(negedge clk);
    check("t5 busy early", busy, 1);
    repeat (6) @(negedge clk);
    check("t5 busy", busy, 0);
    exp_err = 1; exp_sel = 3; exp_wb = 0;
    compare_all("t5");

    run_invalid("t6 nak", 8'h83);

    // Reset pulse in the middle of a read transfer
    send_byte(8'h25);
    send_byte(8'h20);
    send_byte(8'h03);
    n = 0;
    while (tx_log.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6 tx started", tx_log.size() > 0, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("t6 rst busy", busy, 0);
    check("t6 rst outs", {uart_tx_en, rd_en, wr_en, warmboot, error, uart_tx_data}, 0);
    check("t6 rst mem", {mem_select, mem_addr, write_data}, 0);
    resetn = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk);
    exp_sel = 0; exp_wb = 0; exp_err = 0;
    run_read("t6 after", 5, 'h20, 4, 1, 1);

    for (int t = 0; t < 24; t++) begin
      int bank = $urandom_range(0, NB - 1);
      int base = (t % 6 == 5) ? $urandom_range(252, 255) : $urandom_range(0, 255);
      int cnt  = $urandom_range(1, 6);
      int cs   = $urandom_range(0, 1);
      int wb   = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0)
        run_invalid($sformatf("r%0d inv", t), 8'($urandom_range(NB, 15)));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < cnt; i++) wq.push_back(int'(16'($urandom)));
        run_write($sformatf("r%0d wr", t), bank, base, cs, wb,
                  (cs == 1 && $urandom_range(0, 3) == 0) ? 1 : 0);
      end else begin
        run_read($sformatf("r%0d rd", t), bank, base, cnt, cs, wb);
      end
    end

    check("rd_wr overlap", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
